// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and defaults for the MSDAP serial-to-parallel receiver.
// Receiver state encoding and default parameter values live here so the top
// and the optional zero-run detector agree on them.
package s2p_pkg;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    localparam int S2P_DEFAULT_WIDTH    = 16;
    localparam int S2P_DEFAULT_ZERO_RUN = 800;

endpackage

// File: rtl/zero_run_det.sv
// zero_run_det: counts consecutive all-zero completed words and raises sleep
// once ZERO_RUN of them have been seen in a row. Only built into s2p_rx when
// S2P_ZERO_DETECT_EN is defined.
module zero_run_det
    import s2p_pkg::*;
#(
    parameter int ZERO_RUN = S2P_DEFAULT_ZERO_RUN
) (
    input  logic SCLK,
    input  logic CLR_N,
    input  logic word_valid,
    input  logic word_is_zero,
    output logic sleep
);

    localparam int CNT_W = $clog2(ZERO_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(ZERO_RUN);
    localparam logic [CNT_W-1:0] RUN_PRE = CNT_W'(ZERO_RUN - 1);

    logic [CNT_W-1:0] run_cnt;

    // Saturating run counter; sleep is set on the word that completes the run and cleared by any nonzero word.
    always_ff @(posedge SCLK) begin
        if (!CLR_N) begin
            run_cnt <= '0;
            sleep   <= 1'b0;
        end else if (word_valid) begin
            if (word_is_zero) begin
                if (run_cnt != RUN_MAX) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
                sleep <= (run_cnt >= RUN_PRE);
            end else begin
                run_cnt <= '0;
                sleep   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/s2p_rx.sv
// s2p_rx: frame-aligned, MSB-first serial-to-parallel receiver for MSDAP.
// A word starts on FRAME, completes WIDTH bits later with a one-cycle VALID,
// and a FRAME seen mid-word aborts the partial word with a FRAME_ERR pulse
// and restarts capture on that bit.
// Optional feature: define S2P_ZERO_DETECT_EN to add the ZERO_SLEEP output
// driven by a consecutive zero-word counter (zero_run_det).
module s2p_rx
    import s2p_pkg::*;
#(
    parameter int WIDTH = S2P_DEFAULT_WIDTH
`ifdef S2P_ZERO_DETECT_EN
    , parameter int ZERO_RUN = S2P_DEFAULT_ZERO_RUN
`endif
) (
    input  logic             SCLK,
    input  logic             CLR_N,
    input  logic             FRAME,
    input  logic             DATAIN,
    output logic [WIDTH-1:0] PDATAOUT,
    output logic             VALID,
    output logic             BUSY,
    output logic             FRAME_ERR
`ifdef S2P_ZERO_DETECT_EN
    , output logic           ZERO_SLEEP
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = RX_IDLE;
    localparam logic [0:0] ST_SHIFT = RX_SHIFT;

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-2:0] shift_reg;
    logic             word_done;
    logic [WIDTH-1:0] next_word;

    // Detect the cycle in which the final bit of a well-framed word arrives.
    always_comb begin
        word_done = (state == ST_SHIFT) && !FRAME && (count == LAST_CNT);
        next_word = {shift_reg, DATAIN};
    end

    // Receiver FSM, shift register and registered outputs.
    always_ff @(posedge SCLK) begin
        if (!CLR_N) begin
            state     <= ST_IDLE;
            count     <= '0;
            shift_reg <= '0;
            PDATAOUT  <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (FRAME) begin
                if (state == ST_SHIFT) begin
                    FRAME_ERR <= 1'b1;
                end
                shift_reg <= (WIDTH-1)'(DATAIN);
                count     <= CNT_W'(1);
                state     <= ST_SHIFT;
            end else if (word_done) begin
                PDATAOUT  <= next_word;
                VALID     <= 1'b1;
                shift_reg <= '0;
                count     <= '0;
                state     <= ST_IDLE;
            end else if (state == ST_SHIFT) begin
                shift_reg <= (shift_reg << 1) | (WIDTH-1)'(DATAIN);
                count     <= count + CNT_W'(1);
            end
        end
    end

    // A word is in flight whenever the FSM is collecting bits.
    always_comb begin
        BUSY = (state == ST_SHIFT);
    end

`ifdef S2P_ZERO_DETECT_EN
    zero_run_det #(
        .ZERO_RUN     (ZERO_RUN)
    ) u_zero_run_det (
        .SCLK         (SCLK),
        .CLR_N        (CLR_N),
        .word_valid   (word_done),
        .word_is_zero (next_word == '0),
        .sleep        (ZERO_SLEEP)
    );
`endif

endmodule
